// File: rtl/vco_adc_pkg.sv
// ---------------------------------------------------------------------------
// vco_adc_pkg
// Shared definitions for the VCO phase-capture front end.
//   - Ring geometry (NSTAGE inverters, NPOS = 2*NSTAGE ring positions)
//   - Sample, address and synchroniser widths
//   - vcap_state_t : capture FSM states
//   - pos_diff_mod : forward distance between two ring positions, mod NPOS
// ---------------------------------------------------------------------------
package vco_adc_pkg;

    localparam int NSTAGE = 11;
    localparam int NPOS   = 2 * NSTAGE;
    localparam int POS_W  = 5;
    localparam int ACC_W  = 16;
    localparam int ADDR_W = 10;
    localparam int SYNC_N = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } vcap_state_t;

    // Forward ring distance from prev to cur. The VCO never advances a full
    // turn in one clock, so the modular difference is the true advance.
    function automatic logic [POS_W-1:0] pos_diff_mod(input logic [POS_W-1:0] cur,
                                                      input logic [POS_W-1:0] prev);
        logic [POS_W:0] diff;
        if (cur >= prev) begin
            diff = {1'b0, cur} - {1'b0, prev};
        end else begin
            diff = {1'b0, cur} + (POS_W+1)'(NPOS) - {1'b0, prev};
        end
        return diff[POS_W-1:0];
    endfunction

endpackage

// File: rtl/vco_phase_capture_if.sv
// ---------------------------------------------------------------------------
// vco_phase_capture_if
// SRAM write port of the capture block (two banks, shared address/data).
//   csb   : per-bank chip select, active-low
//   web   : per-bank write enable, active-low
//   addr  : word address
//   wmask : byte mask, all ones while a write is driven
//   data  : {sample_odd, sample_even}
// master = capture block, slave = SRAM macro side.
// ---------------------------------------------------------------------------
interface vco_phase_capture_if;
    import vco_adc_pkg::*;

    logic [1:0]        csb;
    logic [1:0]        web;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wmask;
    logic [31:0]       data;

    modport master (output csb, output web, output addr, output wmask, output data);
    modport slave  (input  csb, input  web, input  addr, input  wmask, input  data);
endinterface

// File: rtl/vco_phase_decoder.sv
// ---------------------------------------------------------------------------
// vco_phase_decoder
// Synchronises the raw VCO tap vector and decodes it to a ring position.
//   clk, rst_n : clock, asynchronous active-low reset
//   phase_i    : raw taps, asynchronous to clk
//   pos_o      : registered ring position 0..NPOS-1 (held on an invalid code)
//   valid_o    : registered flag, high when the decoded code was valid
// Latency from phase_i to pos_o is SYNC_N+1 clocks.
// ---------------------------------------------------------------------------
module vco_phase_decoder
    import vco_adc_pkg::*;
#(
    parameter int SYNC_N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSTAGE-1:0] phase_i,
    output logic [POS_W-1:0]  pos_o,
    output logic              valid_o
);

    logic [SYNC_N-1:0][NSTAGE-1:0] sync_q, sync_d;
    logic [NSTAGE-1:0]             taps;
    logic [NSTAGE-1:0]             match;
    logic [POS_W-1:0]              pos_q, pos_d;
    logic                          valid_q, valid_d;
    logic [POS_W-1:0]              hit_k;
    logic                          hit_v;
    logic                          code_ok;

    always_comb begin
        sync_d[0] = phase_i;
        for (int i = 1; i < SYNC_N; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign taps = sync_q[SYNC_N-1];

    // In a settled odd ring exactly one neighbour pair holds equal levels;
    // that pair marks where the edge currently sits.
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_match
        localparam int PREV = (gi + NSTAGE - 1) % NSTAGE;
        assign match[gi] = (taps[gi] == taps[PREV]);
    end

    always_comb begin
        hit_k   = '0;
        hit_v   = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (match[i]) begin
                hit_k = POS_W'(i);
                hit_v = taps[i];
            end
        end
        code_ok = ($countones(match) == 1);
        valid_d = code_ok;
        pos_d   = pos_q;
        if (code_ok) begin
            // The level of the equal pair tells which half-turn the edge is in.
            pos_d = hit_k + (hit_v ? POS_W'(NSTAGE) : POS_W'(0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
        end
    end

    assign pos_o   = pos_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/vco_phase_capture.sv
// ---------------------------------------------------------------------------
// vco_phase_capture
// One VCO channel: decode ring position, accumulate position deltas over a
// decimation window, pack two 16-bit samples per word and write them to SRAM.
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   phase_i             : raw VCO taps
//   start_i / stop_i    : begin capture / abort (stop wins)
//   decim_i, len_i      : window length (0 -> 1), word count (0 -> 1024), latched at start
//   bank_i              : target SRAM bank, latched at start
//   irq_clr_i           : clears irq_o
//   busy_o, irq_o       : capture in progress / capture complete
//   err_cnt_o           : invalid phase codes seen during the capture, saturating
//   mem                 : SRAM write port
// ---------------------------------------------------------------------------
module vco_phase_capture
    import vco_adc_pkg::*;
#(
    parameter int SYNC_N = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic [NSTAGE-1:0]          phase_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [7:0]                 decim_i,
    input  logic [ADDR_W-1:0]          len_i,
    input  logic                       bank_i,
    input  logic                       irq_clr_i,
    output logic                       busy_o,
    output logic                       irq_o,
    output logic [7:0]                 err_cnt_o,
    vco_phase_capture_if.master        mem
);

    localparam int ARM_W = $clog2(SYNC_N + 1);

    logic [POS_W-1:0]  pos;
    logic              pos_valid;

    vcap_state_t       state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [POS_W-1:0]  pos_prev_q, pos_prev_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        win_cnt_q, win_cnt_d;
    logic [7:0]        decim_q, decim_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              bank_q, bank_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic              half_q, half_d;
    logic [ACC_W-1:0]  even_q, even_d;
    logic              irq_q, irq_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [1:0]        csb_q, csb_d;
    logic [1:0]        web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       data_q, data_d;

    logic [POS_W-1:0]  delta;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  sample;
    logic              busy;

    vco_phase_decoder #(.SYNC_N(SYNC_N)) u_dec (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .phase_i (phase_i),
        .pos_o   (pos),
        .valid_o (pos_valid)
    );

    assign busy = (state_q == ARM) || (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        pos_prev_d = pos;
        acc_d      = acc_q;
        win_cnt_d  = win_cnt_q;
        decim_d    = decim_q;
        len_d      = len_q;
        bank_d     = bank_q;
        word_d     = word_q;
        half_d     = half_q;
        even_d     = even_q;
        irq_d      = irq_q & ~irq_clr_i;
        err_cnt_d  = err_cnt_q;
        csb_d      = 2'b11;
        web_d      = 2'b11;
        wmask_d    = 4'h0;
        addr_d     = addr_q;
        data_d     = data_q;

        delta  = pos_diff_mod(pos, pos_prev_q);
        sum    = {1'b0, acc_q} + (ACC_W+1)'(delta);
        sample = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

        if (busy && !pos_valid && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i && !stop_i) begin
                    state_d   = ARM;
                    arm_cnt_d = '0;
                    decim_d   = (decim_i == 8'd0) ? 8'd1 : decim_i;
                    len_d     = len_i;
                    bank_d    = bank_i;
                    err_cnt_d = 8'd0;
                    acc_d     = '0;
                    win_cnt_d = 8'd0;
                    word_d    = '0;
                    half_d    = 1'b0;
                end
            end
            ARM: begin
                // Wait for the synchroniser/decoder pipeline to carry the
                // current phase before deltas are trusted.
                acc_d     = '0;
                win_cnt_d = 8'd0;
                word_d    = '0;
                half_d    = 1'b0;
                if (stop_i) begin
                    state_d = IDLE;
                end else if (arm_cnt_q == ARM_W'(SYNC_N)) begin
                    state_d = RUN;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    half_d  = 1'b0;
                end else if (win_cnt_q == decim_q - 8'd1) begin
                    // Terminal clock: the sample includes this clock's delta and
                    // the next window starts from zero on the following clock.
                    acc_d     = '0;
                    win_cnt_d = 8'd0;
                    if (!half_q) begin
                        even_d = sample;
                        half_d = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        csb_d   = bank_q ? 2'b01 : 2'b10;
                        web_d   = bank_q ? 2'b01 : 2'b10;
                        wmask_d = 4'hF;
                        addr_d  = word_q;
                        data_d  = {sample, even_q};
                        word_d  = word_q + ADDR_W'(1);
                        // len 0 wraps to 1023 here, giving a full 1024-word capture.
                        if (word_q == len_q - ADDR_W'(1)) begin
                            state_d = DONE;
                            irq_d   = 1'b1;
                        end
                    end
                end else begin
                    acc_d     = sample;
                    win_cnt_d = win_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            arm_cnt_q  <= '0;
            pos_prev_q <= '0;
            acc_q      <= '0;
            win_cnt_q  <= 8'd0;
            decim_q    <= 8'd1;
            len_q      <= '0;
            bank_q     <= 1'b0;
            word_q     <= '0;
            half_q     <= 1'b0;
            even_q     <= '0;
            irq_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            csb_q      <= 2'b11;
            web_q      <= 2'b11;
            wmask_q    <= 4'h0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            pos_prev_q <= pos_prev_d;
            acc_q      <= acc_d;
            win_cnt_q  <= win_cnt_d;
            decim_q    <= decim_d;
            len_q      <= len_d;
            bank_q     <= bank_d;
            word_q     <= word_d;
            half_q     <= half_d;
            even_q     <= even_d;
            irq_q      <= irq_d;
            err_cnt_q  <= err_cnt_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign busy_o    = busy;
    assign irq_o     = irq_q;
    assign err_cnt_o = err_cnt_q;
    assign mem.csb   = csb_q;
    assign mem.web   = web_q;
    assign mem.wmask = wmask_q;
    assign mem.addr  = addr_q;
    assign mem.data  = data_q;

endmodule

// File: tb/tb_vco_phase_capture.sv
// ---------------------------------------------------------------------------
// tb_vco_phase_capture
// Directed bench for vco_phase_capture: a ring-oscillator model drives the
// taps, expected SRAM writes are queued at each start and popped as the
// DUT writes them.
// ---------------------------------------------------------------------------
module tb_vco_phase_capture;
    import vco_adc_pkg::*;

    typedef struct {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              chk_data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NSTAGE-1:0] phase_i;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic [7:0]        decim_i = 8'd0;
    logic [ADDR_W-1:0] len_i = '0;
    logic              bank_i = 1'b0;
    logic              irq_clr_i = 1'b0;
    logic              busy_o;
    logic              irq_o;
    logic [7:0]        err_cnt_o;

    int  checks   = 0;
    int  failures = 0;
    int  vco_step = 0;
    int  vco_pos  = 0;
    int  cyc      = 0;
    int  inv_end  = 0;
    int  data_sum = 0;
    wr_t exp_q[$];

    vco_phase_capture_if mem_if();

    vco_phase_capture #(.SYNC_N(SYNC_N)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .phase_i   (phase_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .decim_i   (decim_i),
        .len_i     (len_i),
        .bank_i    (bank_i),
        .irq_clr_i (irq_clr_i),
        .busy_o    (busy_o),
        .irq_o     (irq_o),
        .err_cnt_o (err_cnt_o),
        .mem       (mem_if)
    );

    initial forever #5 clk = ~clk;

    // Tap pattern of an odd ring with its edge at position p: the equal pair
    // sits at (k-1, k) and carries level v, all other neighbours alternate.
    function automatic logic [NSTAGE-1:0] ring_code(input int p);
        logic [NSTAGE-1:0] c;
        int                k;
        logic              v;
        k = p % NSTAGE;
        v = (p >= NSTAGE);
        for (int j = 0; j < NSTAGE; j++) begin
            c[(k + j) % NSTAGE] = v ^ j[0];
        end
        return c;
    endfunction

    // VCO model: advances vco_step positions per clock, taps change away
    // from the clock edge; an all-ones code is shown while cyc < inv_end.
    initial begin
        phase_i = ring_code(0);
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            vco_pos = (vco_pos + vco_step) % NPOS;
            if (cyc < inv_end) phase_i = 11'h7FF;
            else               phase_i = ring_code(vco_pos);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic bk, input int addr, input logic [31:0] d, input logic cd);
        wr_t e;
        e.bank     = bk;
        e.addr     = ADDR_W'(addr);
        e.data     = d;
        e.chk_data = cd;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] dec, input logic [ADDR_W-1:0] ln, input logic bk);
        decim_i = dec;
        len_i   = ln;
        bank_i  = bk;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Watch the SRAM port until n writes were seen or the budget runs out.
    task automatic wait_writes(input int n, input int budget);
        int  seen;
        int  left;
        wr_t e;
        seen = 0;
        left = budget;
        while (seen < n && left > 0) begin
            @(negedge clk);
            left--;
            if (mem_if.csb != 2'b11) begin
                seen++;
                chk("sb_avail", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_csb", 64'(mem_if.csb), e.bank ? 64'h1 : 64'h2);
                    chk("wr_web", 64'(mem_if.web), e.bank ? 64'h1 : 64'h2);
                    chk("wr_wmask", 64'(mem_if.wmask), 64'hF);
                    chk("wr_addr", 64'(mem_if.addr), 64'(e.addr));
                    if (e.chk_data) chk("wr_data", 64'(mem_if.data), 64'(e.data));
                    else data_sum += int'(mem_if.data[31:16]) + int'(mem_if.data[15:0]);
                end
            end
        end
        chk("wr_count", 64'(seen), 64'(n));
    endtask

    task automatic no_write_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("no_write_csb", 64'(mem_if.csb), 64'h3);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_irq",   64'(irq_o), 64'd0);
        chk("rst_err",   64'(err_cnt_o), 64'd0);
        chk("rst_csb",   64'(mem_if.csb), 64'h3);
        chk("rst_web",   64'(mem_if.web), 64'h3);
        chk("rst_addr",  64'(mem_if.addr), 64'd0);
        chk("rst_data",  64'(mem_if.data), 64'd0);
        chk("rst_wmask", 64'(mem_if.wmask), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Constant phase (pos 0), decim 4, len 2
        $display("T1 constant phase decim=4 len=2");
        push_wr(1'b0, 0, 32'h0000_0000, 1'b1);
        push_wr(1'b0, 1, 32'h0000_0000, 1'b1);
        do_start(8'd4, 10'd2, 1'b0);
        chk("t1_busy", 64'(busy_o), 64'd1);
        wait_writes(2, 100);
        @(negedge clk);
        chk("t1_irq", 64'(irq_o), 64'd1);
        chk("t1_busy_done", 64'(busy_o), 64'd0);
        chk("t1_csb_pulse", 64'(mem_if.csb), 64'h3);
        chk("t1_err", 64'(err_cnt_o), 64'd0);

        // One position per clock, decim 8, len 3, bank 1; re-arm from DONE
        $display("T2 step=1 decim=8 len=3 bank=1");
        vco_step = 1;
        repeat (30) @(negedge clk);
        for (int i = 0; i < 3; i++) push_wr(1'b1, i, 32'h0008_0008, 1'b1);
        do_start(8'd8, 10'd3, 1'b1);
        chk("t2_rearm_irq", 64'(irq_o), 64'd1);
        chk("t2_busy", 64'(busy_o), 64'd1);
        irq_clr_i = 1'b1;
        @(negedge clk);
        chk("t2_irq_clr", 64'(irq_o), 64'd0);
        wait_writes(3, 200);
        chk("t2_irq_set_wins", 64'(irq_o), 64'd1);
        @(negedge clk);
        chk("t2_irq_cleared", 64'(irq_o), 64'd0);
        irq_clr_i = 1'b0;
        chk("t2_wrap_no_err", 64'(err_cnt_o), 64'd0);

        // Three invalid codes mid-capture: pos held, total advance preserved
        $display("T3 invalid code x3 decim=8 len=2");
        push_wr(1'b0, 0, 32'h0, 1'b0);
        push_wr(1'b0, 1, 32'h0, 1'b0);
        data_sum = 0;
        do_start(8'd8, 10'd2, 1'b0);
        repeat (8) @(negedge clk);
        inv_end = cyc + 4;
        wait_writes(2, 200);
        chk("t3_sample_sum", 64'(data_sum), 64'd32);
        chk("t3_err_cnt", 64'(err_cnt_o), 64'd3);
        @(negedge clk);
        chk("t3_irq", 64'(irq_o), 64'd1);

        // Stop on the clock after the first even sample
        $display("T4 stop after first even sample");
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        chk("t4_irq_clr", 64'(irq_o), 64'd0);
        do_start(8'd4, 10'd4, 1'b0);
        chk("t4_err_cleared", 64'(err_cnt_o), 64'd0);
        repeat (7) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        chk("t4_stop_idle", 64'(busy_o), 64'd0);
        no_write_cycles(20);
        chk("t4_irq_stays", 64'(irq_o), 64'd0);

        // Single-word capture after an abort
        $display("T5 len=1 decim=4");
        push_wr(1'b0, 0, 32'h0004_0004, 1'b1);
        do_start(8'd4, 10'd1, 1'b0);
        wait_writes(1, 100);
        chk("t5_irq", 64'(irq_o), 64'd1);

        // decim 0 -> 1, len 0 -> 1024, 11 positions per clock
        $display("T6 decim=0 len=0 step=11");
        vco_step = 11;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 1024; i++) push_wr(1'b0, i, 32'h000B_000B, 1'b1);
        do_start(8'd0, 10'd0, 1'b0);
        wait_writes(1024, 2200);
        @(negedge clk);
        chk("t6_irq", 64'(irq_o), 64'd1);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_no_wrap_write", 64'(mem_if.csb), 64'h3);
        chk("t6_sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset asserted during a write cycle
        $display("T7 reset mid-capture");
        vco_step = 1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) push_wr(1'b0, i, 32'h0001_0001, 1'b1);
        do_start(8'd1, 10'd8, 1'b0);
        wait_writes(3, 50);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_csb",   64'(mem_if.csb), 64'h3);
        chk("t7_web",   64'(mem_if.web), 64'h3);
        chk("t7_addr",  64'(mem_if.addr), 64'd0);
        chk("t7_data",  64'(mem_if.data), 64'd0);
        chk("t7_wmask", 64'(mem_if.wmask), 64'd0);
        chk("t7_busy",  64'(busy_o), 64'd0);
        chk("t7_irq",   64'(irq_o), 64'd0);
        chk("t7_err",   64'(err_cnt_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_write_cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
